l2_burst_adaptor: RTL and testbench

- Converts the L2 cache's 256-bit single-transfer physical-memory request into 4-beat × 64-bit bursts for the main-memory model.
- Sits directly downstream of the L2 cache. Its line-side port connects to L2's pmem_* signals; its burst side drives the burst memory.
- Aligns addresses to the line boundary, assembles read lines, serialises write lines, and counts completed bursts for performance statistics.

---
 rtl/l2_burst_adaptor_pkg.sv | 19 +
 rtl/l2_burst_adaptor.sv | 116 +++++++++++
 tb/tb_l2_burst_adaptor.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_burst_adaptor_pkg.sv
// Shared types and constants for the L2 line-to-burst adaptor.
// The line is carried as 4 beats of 64 bits; beat 0 occupies the low bits.
package l2_burst_adaptor_pkg;

  localparam int BEATS_C       = 4;
  localparam int BEAT_IDX_W    = 2;
  localparam int OFFSET_BITS_C = 5;

  typedef logic [255:0] line_t;
  typedef logic [63:0]  beat_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/l2_burst_adaptor.sv
// Bridges the L2 cache's single 256-bit pmem transfer onto a 4-beat x 64-bit
// burst memory: line-aligned address, read-line assembly, write-line serialisation.
module l2_burst_adaptor
  import l2_burst_adaptor_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int OFFSET_BITS = OFFSET_BITS_C
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   line_address_i,
  input  logic                    line_read_i,
  input  logic                    line_write_i,
  input  logic [LINE_WIDTH-1:0]   line_wdata_i,
  output logic [LINE_WIDTH-1:0]   line_rdata_o,
  output logic                    line_resp_o,
  output logic [ADDR_WIDTH-1:0]   burst_address_o,
  output logic                    burst_read_o,
  output logic                    burst_write_o,
  output logic [BURST_WIDTH-1:0]  burst_wdata_o,
  input  logic [BURST_WIDTH-1:0]  burst_rdata_i,
  input  logic                    burst_resp_i,
  output logic [31:0]             read_burst_count_o,
  output logic [31:0]             write_burst_count_o
);

  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(ADDR_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  adaptor_state_t state;
  logic [IDX_W-1:0] cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  // Beat-indexed views of the two lines so the beat counter selects a slice directly.
  logic [BEATS-1:0][BURST_WIDTH-1:0] rd_line;
  logic [BEATS-1:0][BURST_WIDTH-1:0] wr_line;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      // NOTE: the line buffers are plain registers, not RAM, so they can and
      // do take the reset; line_rdata_o and burst_wdata_o must read 0 in reset.
      rd_line  <= '0;
      wr_line  <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (line_write_i) begin
            addr_q  <= line_address_i;
            wr_line <= line_wdata_i;
            state   <= WR_BURST;
          end else if (line_read_i) begin
            addr_q <= line_address_i;
            state  <= RD_BURST;
          end
        end

        RD_BURST: begin
          if (burst_resp_i) begin
            rd_line[cnt] <= burst_rdata_i;
            if (cnt == LAST_BEAT) begin
              cnt      <= '0;
              rd_count <= rd_count + 32'd1;
              state    <= DONE;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end

        WR_BURST: begin
          if (burst_resp_i) begin
            if (cnt == LAST_BEAT) begin
              cnt      <= '0;
              wr_count <= wr_count + 32'd1;
              state    <= DONE;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end

        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only; no input reaches an output.
  assign burst_read_o        = (state == RD_BURST);
  assign burst_write_o       = (state == WR_BURST);
  assign line_resp_o         = (state == DONE);
  assign burst_address_o     = addr_q & ALIGN_MASK;
  assign burst_wdata_o       = wr_line[cnt];
  assign line_rdata_o        = rd_line;
  assign read_burst_count_o  = rd_count;
  assign write_burst_count_o = wr_count;

endmodule

// File: tb/tb_l2_burst_adaptor.sv
// Scoreboard bench for l2_burst_adaptor: a driver acts as both L2 and the burst
// memory and queues expected line responses; a monitor checks every cycle.
module tb_l2_burst_adaptor;
  import l2_burst_adaptor_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] line_address_i = '0;
  logic        line_read_i = 1'b0;
  logic        line_write_i = 1'b0;
  line_t       line_wdata_i = '0;
  line_t       line_rdata_o;
  logic        line_resp_o;
  logic [31:0] burst_address_o;
  logic        burst_read_o;
  logic        burst_write_o;
  beat_t       burst_wdata_o;
  beat_t       burst_rdata_i = '0;
  logic        burst_resp_i = 1'b0;
  logic [31:0] read_burst_count_o;
  logic [31:0] write_burst_count_o;

  l2_burst_adaptor dut (
    .clk                 (clk),
    .rst                 (rst),
    .line_address_i      (line_address_i),
    .line_read_i         (line_read_i),
    .line_write_i        (line_write_i),
    .line_wdata_i        (line_wdata_i),
    .line_rdata_o        (line_rdata_o),
    .line_resp_o         (line_resp_o),
    .burst_address_o     (burst_address_o),
    .burst_read_o        (burst_read_o),
    .burst_write_o       (burst_write_o),
    .burst_wdata_o       (burst_wdata_o),
    .burst_rdata_i       (burst_rdata_i),
    .burst_resp_i        (burst_resp_i),
    .read_burst_count_o  (read_burst_count_o),
    .write_burst_count_o (write_burst_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_write;
    line_t       line;
    logic [31:0] rcnt;
    logic [31:0] wcnt;
  } exp_t;

  exp_t sb[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: what the adaptor should have observed so far.
  line_t       last_line_m = '0;
  logic [31:0] rd_cnt_m    = '0;
  logic [31:0] wr_cnt_m    = '0;

  // Burst-side expectations published by the driver for the monitor.
  logic        exp_rd_active = 1'b0;
  logic        exp_wr_active = 1'b0;
  logic [31:0] exp_addr      = '0;
  beat_t       exp_wbeat     = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic beat_t rand_beat();
    return {$urandom, $urandom};
  endfunction

  // Monitor: compares burst-side activity every cycle and pops the scoreboard
  // whenever the adaptor presents a line response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("burst_read", 256'(burst_read_o), 256'(exp_rd_active));
        check("burst_write", 256'(burst_write_o), 256'(exp_wr_active));
        if (exp_rd_active || exp_wr_active)
          check("burst_address", 256'(burst_address_o), 256'(exp_addr));
        if (exp_wr_active)
          check("burst_wdata", 256'(burst_wdata_o), 256'(exp_wbeat));
        if (line_resp_o) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_resp: got line_resp_o=1 expected no pending request (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            check("resp_rdata", line_rdata_o, e.line);
            check("resp_read_count", 256'(read_burst_count_o), 256'(e.rcnt));
            check("resp_write_count", 256'(write_burst_count_o), 256'(e.wcnt));
          end
        end
      end
    end
  end

  // One L2 request plus the memory side of its burst. waits packs a 2-bit
  // wait count per beat; abort_after >= 0 pulls reset before that beat.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input line_t data, input logic [7:0] waits, input int abort_after);
    exp_t e;
    line_read_i    = rd;
    line_write_i   = wr;
    line_address_i = addr;
    line_wdata_i   = wr ? data : rand_line();
    burst_resp_i   = 1'($urandom_range(0, 1));
    burst_rdata_i  = rand_beat();
    if (wr) wr_cnt_m = wr_cnt_m + 32'd1;
    else begin
      rd_cnt_m    = rd_cnt_m + 32'd1;
      last_line_m = data;
    end
    e.is_write = wr;
    e.line     = last_line_m;
    e.rcnt     = rd_cnt_m;
    e.wcnt     = wr_cnt_m;
    sb.push_back(e);
    @(posedge clk); #1;
    // Scramble the request-side inputs: the adaptor must use latched copies.
    line_wdata_i   = ~data;
    line_address_i = ~addr;
    exp_addr       = {addr[31:5], 5'b0};
    exp_rd_active  = !wr;
    exp_wr_active  = wr;
    for (int k = 0; k < BEATS_C; k++) begin
      exp_wbeat = data[k*64 +: 64];
      repeat (int'(waits[2*k +: 2])) begin
        burst_resp_i  = 1'b0;
        burst_rdata_i = rand_beat();
        @(posedge clk); #1;
      end
      if (abort_after == k) begin
        rst           = 1'b0;
        exp_rd_active = 1'b0;
        exp_wr_active = 1'b0;
        void'(sb.pop_back());
        rd_cnt_m    = '0;
        wr_cnt_m    = '0;
        last_line_m = '0;
        #1;
        check("abort_burst_read", 256'(burst_read_o), 256'(1'b0));
        check("abort_burst_write", 256'(burst_write_o), 256'(1'b0));
        check("abort_line_resp", 256'(line_resp_o), 256'(1'b0));
        check("abort_read_count", 256'(read_burst_count_o), 256'(rd_cnt_m));
        check("abort_rdata", line_rdata_o, last_line_m);
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        burst_resp_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      burst_resp_i  = 1'b1;
      burst_rdata_i = data[k*64 +: 64];
      @(posedge clk); #1;
    end
    // DONE cycle: drop the request and throw in a stray memory response.
    exp_rd_active = 1'b0;
    exp_wr_active = 1'b0;
    burst_resp_i  = 1'($urandom_range(0, 1));
    burst_rdata_i = rand_beat();
    line_read_i   = 1'b0;
    line_write_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      burst_resp_i  = 1'($urandom_range(0, 1));
      burst_rdata_i = rand_beat();
      @(posedge clk); #1;
    end
    burst_resp_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    line_t l;
    // Reset held with a read request pending: everything stays quiet.
    rst            = 1'b0;
    line_read_i    = 1'b1;
    line_address_i = 32'h0000_1234;
    burst_resp_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_burst_read", 256'(burst_read_o), 256'(1'b0));
      check("rst_burst_write", 256'(burst_write_o), 256'(1'b0));
      check("rst_line_resp", 256'(line_resp_o), 256'(1'b0));
      check("rst_burst_address", 256'(burst_address_o), 256'(32'h0));
      check("rst_burst_wdata", 256'(burst_wdata_o), 256'(64'h0));
      check("rst_line_rdata", line_rdata_o, 256'h0);
      check("rst_read_count", 256'(read_burst_count_o), 256'(32'h0));
      check("rst_write_count", 256'(write_burst_count_o), 256'(32'h0));
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // Read with no wait states at 0x1234 -> burst at 0x1220.
    run_op(1'b1, 1'b0, 32'h0000_1234,
           {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 8'h00, -1);

    // Write with response pattern 1,0,0,1,1,0,1.
    run_op(1'b0, 1'b1, 32'h0000_2000,
           {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
           {2'd1, 2'd0, 2'd2, 2'd0}, -1);

    // Simultaneous read and write: only the write happens.
    run_op(1'b1, 1'b1, 32'h0000_0040, rand_line(), 8'h00, -1);

    // Reset after two read beats, then a full read.
    run_op(1'b1, 1'b0, $urandom, rand_line(), 8'h00, 2);
    run_op(1'b1, 1'b0, $urandom, rand_line(), {2'd0, 2'd1, 2'd0, 2'd2}, -1);

    // Back-to-back read then write, then stray responses in IDLE before a read.
    run_op(1'b1, 1'b0, $urandom, rand_line(), 8'h00, -1);
    run_op(1'b0, 1'b1, $urandom, rand_line(), 8'h00, -1);
    burst_resp_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    burst_resp_i = 1'b0;
    run_op(1'b1, 1'b0, $urandom, rand_line(), 8'h00, -1);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      int kind;
      idle_cycles($urandom_range(0, 2));
      kind = $urandom_range(0, 9);
      l    = rand_line();
      if (kind < 5)      run_op(1'b1, 1'b0, $urandom, l, 8'($urandom), -1);
      else if (kind < 9) run_op(1'b0, 1'b1, $urandom, l, 8'($urandom), -1);
      else               run_op(1'b1, 1'b1, $urandom, l, 8'($urandom), -1);
    end

    idle_cycles(3);
    check("scoreboard_drained", 256'(sb.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
